// File: rtl/lfsr_gen_if.sv
// Control/status bundle for lfsr_gen: step/load/mode controls in, state and
// period-measurement flags out.
interface lfsr_gen_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] num;
    logic             bit_out;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             lockup;

    modport master (
        output en, mode, load, load_val,
        input  num, bit_out, wrap, period, period_valid, lockup
    );

    modport slave (
        input  en, mode, load, load_val,
        output num, bit_out, wrap, period, period_valid, lockup
    );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with run-time Fibonacci/Galois select, seed load,
// zero-state recovery and sequence-period measurement.
module lfsr_gen #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
    parameter logic [WIDTH-1:0] SEED  = 4'b1000
) (
    input  logic        clk,
    input  logic        reset,
    lfsr_gen_if.slave   bus
);

    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             wrap;
    logic             lockup;

    logic [WIDTH-1:0] gal_mask;
    logic [WIDTH-1:0] fib_nxt;
    logic [WIDTH-1:0] gal_nxt;
    logic [WIDTH-1:0] nxt;

    // Galois mask is TAPS mirrored, so both modes realise the same polynomial
    // and visit a sequence of the same length from any non-zero start.
    for (genvar i = 0; i < WIDTH; i++) begin : g_mirror
        assign gal_mask[i] = TAPS[WIDTH-1-i];
    end

    always_comb begin
        fib_nxt = {^(num & TAPS), num[WIDTH-1:1]};
        gal_nxt = {1'b0, num[WIDTH-1:1]} ^ ({WIDTH{num[0]}} & gal_mask);
        nxt     = bus.mode ? gal_nxt : fib_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num          <= SEED;
            start        <= SEED;
            step_cnt     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            lockup       <= 1'b0;
        end else if (bus.load) begin
            step_cnt     <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
            if (bus.load_val == '0) begin
                num    <= SEED;
                start  <= SEED;
                lockup <= 1'b1;
            end else begin
                num    <= bus.load_val;
                start  <= bus.load_val;
                lockup <= 1'b0;
            end
        end else if (bus.en) begin
            if (num == '0) begin
                // Only reachable through state corruption; restart cleanly.
                num      <= SEED;
                step_cnt <= '0;
                wrap     <= 1'b0;
                lockup   <= 1'b1;
            end else begin
                num    <= nxt;
                lockup <= 1'b0;
                if (nxt == start) begin
                    period       <= step_cnt + 1'b1;
                    period_valid <= 1'b1;
                    step_cnt     <= '0;
                    wrap         <= 1'b1;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                    wrap     <= 1'b0;
                end
            end
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end
    end

    assign bus.num          = num;
    assign bus.bit_out      = num[0];
    assign bus.wrap         = wrap;
    assign bus.period       = period;
    assign bus.period_valid = period_valid;
    assign bus.lockup       = lockup;

endmodule
